// File: rtl/swd_host.sv
// SWD host engine: serialises one DP/AP request (or a line reset) onto the
// SWDCLK/SWDOUT/SWDOUTEN/SWDIN pins of an external bidirectional buffer.
module swd_host #(
    parameter int CLK_DIV   = 4,
    parameter int IDLE_BITS = 2
) (
    input  logic        hclk,
    input  logic        RESET,
    // req_valid/line_reset are taken only in a cycle where req_ready=1; rsp_valid
    // is a one-cycle pulse with no back-pressure, and rsp_* hold until the next pulse.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_apndp,
    input  logic        req_rnw,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic        line_reset,
    output logic        rsp_valid,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_perr,
    output logic        SWDCLK,
    output logic        SWDOUT,
    output logic        SWDOUTEN,
    input  logic        SWDIN,
    output logic [3:0]  o_state
);

    typedef enum logic [3:0] {
        IDLE, LRST, REQ, TRN1, ACK, RDATA, TRN2, WDATA, TAIL
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [5:0] TAIL_LAST = 6'(IDLE_BITS - 1);
    localparam state_t     POST_DATA = (IDLE_BITS == 0) ? IDLE : TAIL;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_div;
    logic        r_phase;
    logic [5:0]  r_bitcnt;
    logic        r_apndp;
    logic        r_rnw;
    logic [1:0]  r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_ack;
    logic [31:0] r_rd_sh;
    logic        r_rd_par;
    logic        r_rsp_valid;
    logic [2:0]  r_rsp_ack;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_perr;

    logic        w_bit_end;
    logic        w_sample;
    logic        w_last;
    logic        w_req_par;
    logic [7:0]  w_req_byte;
    logic [2:0]  w_ack_now;
    logic        w_swdout;
    logic        w_swdouten;

    // Phase 0 is the SWDCLK-low half, phase 1 the high half.
    assign w_bit_end  = r_phase && (r_div == DIV_LAST);
    assign w_sample   = r_phase && (r_div == 8'd0);
    assign w_req_par  = r_apndp ^ r_rnw ^ r_addr[0] ^ r_addr[1];
    assign w_req_byte = {1'b1, 1'b0, w_req_par, r_addr[1], r_addr[0], r_rnw, r_apndp, 1'b1};
    // With CLK_DIV=1 the last ACK bit is sampled on the same edge that ends it.
    assign w_ack_now  = (w_sample && r_state == ACK) ? {SWDIN, r_ack[2:1]} : r_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        w_swdout    = 1'b1;
        w_swdouten  = 1'b0;
        case (r_state)
            IDLE: begin
                if (line_reset)     w_state_nxt = LRST;
                else if (req_valid) w_state_nxt = REQ;
            end
            LRST: begin
                w_swdouten = 1'b1;
                w_swdout   = (r_bitcnt < 6'd56);
                w_last     = (r_bitcnt == 6'd63);
                if (w_bit_end && w_last) w_state_nxt = IDLE;
            end
            REQ: begin
                w_swdouten = 1'b1;
                w_swdout   = w_req_byte[r_bitcnt[2:0]];
                w_last     = (r_bitcnt == 6'd7);
                if (w_bit_end && w_last) w_state_nxt = TRN1;
            end
            TRN1: begin
                w_last = 1'b1;
                if (w_bit_end) w_state_nxt = ACK;
            end
            ACK: begin
                w_last = (r_bitcnt == 6'd2);
                if (w_bit_end && w_last)
                    w_state_nxt = (w_ack_now == 3'b001 && r_rnw) ? RDATA : TRN2;
            end
            RDATA: begin
                w_last = (r_bitcnt == 6'd32);
                if (w_bit_end && w_last) w_state_nxt = TRN2;
            end
            TRN2: begin
                w_last = 1'b1;
                if (w_bit_end)
                    w_state_nxt = (r_ack == 3'b001 && !r_rnw) ? WDATA : POST_DATA;
            end
            WDATA: begin
                w_swdouten = 1'b1;
                w_swdout   = (r_bitcnt == 6'd32) ? ^r_wdata : r_wdata[r_bitcnt[4:0]];
                w_last     = (r_bitcnt == 6'd32);
                if (w_bit_end && w_last) w_state_nxt = POST_DATA;
            end
            TAIL: begin
                w_swdouten = 1'b1;
                w_swdout   = 1'b0;
                w_last     = (r_bitcnt == TAIL_LAST);
                if (w_bit_end && w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_div       <= 8'd0;
            r_phase     <= 1'b0;
            r_bitcnt    <= 6'd0;
            r_apndp     <= 1'b0;
            r_rnw       <= 1'b0;
            r_addr      <= 2'd0;
            r_wdata     <= 32'd0;
            r_ack       <= 3'd0;
            r_rd_sh     <= 32'd0;
            r_rd_par    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_ack   <= 3'd0;
            r_rsp_rdata <= 32'd0;
            r_rsp_perr  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= 1'b0;
            if (r_state == IDLE) begin
                r_div    <= 8'd0;
                r_phase  <= 1'b0;
                r_bitcnt <= 6'd0;
                if (req_valid && !line_reset) begin
                    r_apndp <= req_apndp;
                    r_rnw   <= req_rnw;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                end
            end else begin
                if (r_div == DIV_LAST) begin
                    r_div   <= 8'd0;
                    r_phase <= ~r_phase;
                end else begin
                    r_div <= r_div + 8'd1;
                end
                if (w_sample) begin
                    if (r_state == ACK)
                        r_ack <= {SWDIN, r_ack[2:1]};
                    else if (r_state == RDATA) begin
                        if (r_bitcnt == 6'd32) r_rd_par <= SWDIN;
                        else                   r_rd_sh  <= {SWDIN, r_rd_sh[31:1]};
                    end
                end
                if (w_bit_end)
                    r_bitcnt <= (w_state_nxt != r_state) ? 6'd0 : r_bitcnt + 6'd1;
                if (w_state_nxt == IDLE) begin
                    r_rsp_valid <= 1'b1;
                    if (r_state == LRST) begin
                        r_rsp_ack  <= 3'b000;
                        r_rsp_perr <= 1'b0;
                    end else begin
                        r_rsp_ack <= r_ack;
                        if (r_ack == 3'b001 && r_rnw) begin
                            r_rsp_rdata <= r_rd_sh;
                            r_rsp_perr  <= (^r_rd_sh) != r_rd_par;
                        end else begin
                            r_rsp_perr <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign req_ready = (r_state == IDLE) && !RESET;
    assign rsp_valid = r_rsp_valid;
    assign rsp_ack   = r_rsp_ack;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_perr  = r_rsp_perr;
    assign SWDCLK    = r_phase;
    assign SWDOUT    = w_swdout;
    assign SWDOUTEN  = w_swdouten;
    assign o_state   = r_state;

endmodule

// File: tb/tb_swd_host.sv
// Bench for swd_host: a wire-level target model answers ACK/data on SWDIN and
// records every host bit; responses are checked against an expected queue.
module tb_swd_host;

  localparam int CLK_DIV   = 2;
  localparam int IDLE_BITS = 2;
  localparam int EW        = 43;  // {ack[2:0], rdata[31:0], perr, len[6:0]}

  logic        hclk;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_apndp;
  logic        req_rnw;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        line_reset;
  logic        rsp_valid;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_perr;
  logic        SWDCLK;
  logic        SWDOUT;
  logic        SWDOUTEN;
  logic        SWDIN;
  logic [3:0]  dbg_state;

  swd_host #(.CLK_DIV(CLK_DIV), .IDLE_BITS(IDLE_BITS)) dut (
    .hclk(hclk), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_apndp(req_apndp), .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
    .line_reset(line_reset),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
    .SWDCLK(SWDCLK), .SWDOUT(SWDOUT), .SWDOUTEN(SWDOUTEN), .SWDIN(SWDIN),
    .o_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // ---------------- target model ----------------
  logic tgt_bits [0:63];
  logic wire_out [0:79];
  logic wire_oen [0:79];
  int   bitidx;
  int   last_len;
  logic prev_clk;

  initial begin
    bitidx   = 0;
    last_len = 0;
    prev_clk = 1'b0;
    SWDIN    = 1'b1;
    for (int i = 0; i < 64; i++) tgt_bits[i] = 1'b1;
  end

  always @(negedge hclk) begin
    if (rsp_valid) last_len = bitidx;
    if (req_ready) bitidx = 0;
    if (SWDCLK && !prev_clk) begin
      if (bitidx < 80) begin
        wire_out[bitidx] = SWDOUT;
        wire_oen[bitidx] = SWDOUTEN;
      end
      bitidx++;
    end
    if (!SWDCLK && prev_clk) SWDIN = (bitidx < 64) ? tgt_bits[bitidx] : 1'b1;
    prev_clk = SWDCLK;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total;
  int bad;
  logic [31:0] exp_rdata;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(negedge hclk);
    #1;
  endtask

  function automatic logic [7:0] req_byte(input logic ap, input logic rnw, input logic [1:0] a);
    logic p;
    p = ap ^ rnw ^ a[0] ^ a[1];
    return {1'b1, 1'b0, p, a[1], a[0], rnw, ap, 1'b1};
  endfunction

  task automatic set_target(input logic [2:0] ack, input logic [31:0] data, input logic par);
    for (int i = 0; i < 64; i++) tgt_bits[i] = 1'b1;
    for (int i = 0; i < 3; i++) tgt_bits[9 + i] = ack[i];
    for (int i = 0; i < 32; i++) tgt_bits[12 + i] = data[i];
    tgt_bits[44] = par;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    if (!req_ready) chk("ready_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_rsp();
    int n;
    logic [EW-1:0] e;
    n = 0;
    while (!rsp_valid && n < 2000) begin
      tick();
      n++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'd1, 64'd0);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      return;
    end
    chk("ready_with_rsp", 64'(req_ready), 64'd1);
    if (exp_q.size() == 0) begin
      chk("rsp_unexpected", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("rsp_ack", 64'(rsp_ack), 64'(e[42:40]));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e[39:8]));
    chk("rsp_perr", 64'(rsp_perr), 64'(e[7]));
    chk("bit_periods", 64'(last_len), 64'(e[6:0]));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        apndp;
    logic        rnw;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  tack;
    logic [31:0] tdata;
    logic        tpar;
    logic [7:0]  e_byte;
    logic [2:0]  e_ack;
    logic [31:0] e_rdata;
    logic        e_perr;
    int          e_len;
  } vec_t;

  vec_t vecs [12];

  task automatic run_vec(input vec_t v, input logic poke);
    logic [7:0]  got_byte;
    logic        all_oen;
    logic        any_oen;
    logic [31:0] got_w;
    logic        saw_clk;
    int          L;
    set_target(v.tack, v.tdata, v.tpar);
    exp_q.push_back({v.e_ack, v.e_rdata, v.e_perr, 7'(v.e_len)});
    wait_ready();
    req_apndp = v.apndp;
    req_rnw   = v.rnw;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_apndp = 1'b0;
    req_wdata = 32'h0;
    chk("ready_drop", 64'(req_ready), 64'd0);
    if (poke) begin
      repeat (10) tick();
      req_valid  = 1'b1;
      line_reset = 1'b1;
      tick();
      req_valid  = 1'b0;
      line_reset = 1'b0;
    end
    wait_rsp();
    L = v.e_len;
    all_oen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got_byte[i] = wire_out[i];
      all_oen     = all_oen & wire_oen[i];
    end
    chk("req_byte", {55'd0, all_oen, got_byte}, {55'd0, 1'b1, v.e_byte});
    any_oen = 1'b0;
    for (int i = 8; i < 13; i++) any_oen = any_oen | wire_oen[i];
    chk("trn_ack_oen", 64'(any_oen), 64'd0);
    if (v.tack == 3'b001 && !v.rnw) begin
      all_oen = 1'b1;
      for (int i = 0; i < 32; i++) begin
        got_w[i] = wire_out[13 + i];
        all_oen  = all_oen & wire_oen[13 + i];
      end
      chk("wdata", {31'd0, all_oen, got_w}, {31'd0, 1'b1, v.wdata});
      chk("wpar", {62'd0, wire_oen[45], wire_out[45]}, {62'd0, 1'b1, ^v.wdata});
    end
    if (v.tack == 3'b001 && v.rnw) begin
      any_oen = 1'b0;
      for (int i = 12; i < 46; i++) any_oen = any_oen | wire_oen[i];
      chk("rdata_oen", 64'(any_oen), 64'd0);
    end
    for (int i = L - IDLE_BITS; i < L; i++)
      chk("tail_bit", {62'd0, wire_oen[i], wire_out[i]}, {62'd0, 1'b1, 1'b0});
    tick();
    chk("pulse_once", 64'(rsp_valid), 64'd0);
    if (poke) begin
      saw_clk = 1'b0;
      for (int i = 0; i < 30; i++) begin
        tick();
        saw_clk = saw_clk | SWDCLK | !req_ready | rsp_valid;
      end
      chk("no_queued_req", 64'(saw_clk), 64'd0);
    end
    exp_rdata = v.e_rdata;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic ok_seq;
    int   n;
    total      = 0;
    bad        = 0;
    exp_rdata  = 32'h0;
    RESET      = 1'b1;
    req_valid  = 1'b0;
    req_apndp  = 1'b0;
    req_rnw    = 1'b0;
    req_addr   = 2'd0;
    req_wdata  = 32'h0;
    line_reset = 1'b0;

    //                 ap    rnw   addr   wdata         tack    tdata         tpar  byte   eack    erdata        eperr len
    vecs[0] = '{1'b0, 1'b1, 2'd0, 32'h0,        3'b001, 32'h2BA01477, 1'b0, 8'hA5, 3'b001, 32'h2BA01477, 1'b0, 48};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 32'hDEADBEEF, 3'b001, 32'h0,        1'b0, 8'h8B, 3'b001, 32'h2BA01477, 1'b0, 48};
    vecs[2] = '{1'b0, 1'b1, 2'd1, 32'h0,        3'b010, 32'h12345678, 1'b1, 8'h8D, 3'b010, 32'h2BA01477, 1'b0, 15};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h0,        3'b001, 32'h00000001, 1'b0, 8'h87, 3'b001, 32'h00000001, 1'b1, 48};
    vecs[4] = '{1'b0, 1'b0, 2'd2, 32'hCAFEF00D, 3'b100, 32'h0,        1'b0, 8'hB1, 3'b100, 32'h00000001, 1'b0, 15};
    vecs[5] = '{1'b1, 1'b1, 2'd3, 32'h0,        3'b111, 32'hFFFFFFFF, 1'b1, 8'h9F, 3'b111, 32'h00000001, 1'b0, 15};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 32'h0,        3'b001, 32'h80000001, 1'b0, 8'hBD, 3'b001, 32'h80000001, 1'b0, 48};
    vecs[7] = '{1'b1, 1'b1, 2'd2, 32'h0,        3'b001, 32'hFFFFFFFE, 1'b1, 8'hB7, 3'b001, 32'hFFFFFFFE, 1'b0, 48};
    vecs[8] = '{1'b1, 1'b0, 2'd0, 32'h0F0F0F0F, 3'b010, 32'h0,        1'b0, 8'hA3, 3'b010, 32'hFFFFFFFE, 1'b0, 15};
    for (int i = 9; i < 12; i++) begin
      vecs[i].apndp   = 1'($urandom_range(0, 1));
      vecs[i].rnw     = 1'b1;
      vecs[i].addr    = 2'($urandom_range(0, 3));
      vecs[i].wdata   = 32'h0;
      vecs[i].tack    = 3'b001;
      vecs[i].tdata   = $urandom();
      vecs[i].tpar    = 1'($urandom_range(0, 1));
      vecs[i].e_byte  = req_byte(vecs[i].apndp, 1'b1, vecs[i].addr);
      vecs[i].e_ack   = 3'b001;
      vecs[i].e_rdata = vecs[i].tdata;
      vecs[i].e_perr  = (^vecs[i].tdata) != vecs[i].tpar;
      vecs[i].e_len   = 46 + IDLE_BITS;
    end

    // reset values
    repeat (3) tick();
    chk("reset_pins", {59'd0, SWDCLK, SWDOUT, SWDOUTEN, req_ready, rsp_valid},
        {59'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset_rsp", {28'd0, rsp_ack, rsp_perr, rsp_rdata}, 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    RESET = 1'b0;
    tick();
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i == 2);

    // line reset wins over a simultaneous request
    set_target(3'b001, 32'h0, 1'b0);
    exp_q.push_back({3'b000, exp_rdata, 1'b0, 7'd64});
    wait_ready();
    line_reset = 1'b1;
    req_valid  = 1'b1;
    req_rnw    = 1'b1;
    tick();
    line_reset = 1'b0;
    req_valid  = 1'b0;
    chk("lrst_ready_drop", 64'(req_ready), 64'd0);
    wait_rsp();
    ok_seq = 1'b1;
    for (int i = 0; i < 56; i++) ok_seq = ok_seq & wire_out[i] & wire_oen[i];
    chk("lrst_high", 64'(ok_seq), 64'd1);
    ok_seq = 1'b1;
    for (int i = 56; i < 64; i++) ok_seq = ok_seq & !wire_out[i] & wire_oen[i];
    chk("lrst_low", 64'(ok_seq), 64'd1);

    // RESET during RDATA bit 10 aborts silently
    set_target(3'b001, 32'hA5A5A5A5, 1'b0);
    wait_ready();
    req_rnw   = 1'b1;
    req_addr  = 2'd0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (bitidx != 23 && n < 1000) begin
      tick();
      n++;
    end
    chk("reach_rdata_bit10", 64'(bitidx), 64'd23);
    RESET = 1'b1;
    tick();
    chk("abort_pins", {60'd0, SWDCLK, SWDOUTEN, rsp_valid, req_ready}, 64'd0);
    chk("abort_state", 64'(dbg_state), 64'd0);
    RESET = 1'b0;
    exp_rdata = 32'h0;
    ok_seq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ok_seq = ok_seq | rsp_valid;
    end
    chk("abort_no_rsp", 64'(ok_seq), 64'd0);
    run_vec(vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
